// File: rtl/tick_scheduler.sv
// tick_scheduler: shared time base for slow peripherals.
// A base prescaler divides clk into a one-cycle base tick. Four channels count
// base ticks and emit a one-cycle enable pulse plus a 50%-duty toggle each time
// their programmed period elapses. Periods/enables are changed through a
// valid/ready request that is committed only on a base-tick boundary.
//
// Ports:
//   clk         board clock, all logic on posedge
//   rst         synchronous active-high reset
//   cfg_valid   config request valid
//   cfg_ready   request can be accepted (combinational: IDLE and not in reset)
//   cfg_ch      target channel 0..3
//   cfg_period  new period in base ticks (0 forces the channel off)
//   cfg_en      new enable for the channel
//   cfg_done    one-cycle pulse after the request has been committed
//   tick        per-channel one-cycle enable pulse
//   tog         per-channel square wave, flips on every tick
//   ch_en       readback of committed channel enables
module tick_scheduler #(
   parameter int unsigned PRESCALE = 100,
   parameter int unsigned PW       = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [1:0]    cfg_ch,
   input  logic [PW-1:0] cfg_period,
   input  logic          cfg_en,
   output logic          cfg_done,
   output logic [3:0]    tick,
   output logic [3:0]    tog,
   output logic [3:0]    ch_en
);

   localparam int unsigned CW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned NCH   = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [CW-1:0]   r_pcnt;
   logic            w_base_tick;

   logic [PW-1:0]   r_per  [NCH];
   logic [PW-1:0]   r_ccnt [NCH];
   logic [NCH-1:0]  r_en;
   logic [NCH-1:0]  r_tick;
   logic [NCH-1:0]  r_tog;
   logic            r_cfg_done;

   logic [1:0]      r_lat_ch;
   logic [PW-1:0]   r_lat_per;
   logic            r_lat_en;

   logic            w_accept;
   logic            w_commit;

   // Base prescaler: 0..PRESCALE-1, base tick on the last count
   assign w_base_tick = (r_pcnt == CW'(PRESCALE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pcnt <= '0;
      end else if (w_base_tick) begin
         r_pcnt <= '0;
      end else begin
         r_pcnt <= r_pcnt + CW'(1);
      end
   end

   // Config FSM: state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Config FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept)    w_state_nxt = S_WAIT;
         S_WAIT:  if (w_base_tick) w_state_nxt = S_DONE;
         S_DONE:                   w_state_nxt = S_IDLE;
         default:                  w_state_nxt = S_IDLE;
      endcase
   end

   // Config FSM: outputs and handshake strobes
   always_comb begin
      cfg_ready = 1'b0;
      w_accept  = 1'b0;
      w_commit  = 1'b0;
      if (r_state == S_IDLE && !rst) begin
         cfg_ready = 1'b1;
      end
      w_accept = cfg_valid && cfg_ready;
      if (r_state == S_WAIT && w_base_tick) begin
         w_commit = 1'b1;
      end
   end

   // Request latch, captured on accept and held through WAIT/DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lat_ch  <= '0;
         r_lat_per <= '0;
         r_lat_en  <= 1'b0;
      end else if (w_accept) begin
         r_lat_ch  <= cfg_ch;
         r_lat_per <= cfg_period;
         r_lat_en  <= cfg_en;
      end
   end

   // Channel counters; a commit to a channel overrides its count/tick on that base tick
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            r_per[i]  <= '0;
            r_ccnt[i] <= '0;
         end
         r_en       <= '0;
         r_tick     <= '0;
         r_tog      <= '0;
         r_cfg_done <= 1'b0;
      end else begin
         r_tick     <= '0;
         r_cfg_done <= w_commit;
         for (int i = 0; i < NCH; i++) begin
            if (w_commit && (r_lat_ch == 2'(i))) begin
               r_per[i]  <= r_lat_per;
               // a zero period would never reach terminal count, so it disables
               r_en[i]   <= r_lat_en && (r_lat_per != '0);
               r_ccnt[i] <= '0;
               r_tog[i]  <= 1'b0;
            end else if (w_base_tick && r_en[i]) begin
               if (r_ccnt[i] == (r_per[i] - PW'(1))) begin
                  r_ccnt[i] <= '0;
                  r_tick[i] <= 1'b1;
                  r_tog[i]  <= ~r_tog[i];
               end else begin
                  r_ccnt[i] <= r_ccnt[i] + PW'(1);
               end
            end
         end
      end
   end

   assign cfg_done = r_cfg_done;
   assign tick     = r_tick;
   assign tog      = r_tog;
   assign ch_en    = r_en;

endmodule

// File: tb/tb_tick_scheduler.sv
// Bench for tick_scheduler with PRESCALE=4: directed vector table, hand-written
// corner sequences and randomized traffic, all checked against an arithmetic
// reference model evaluated every cycle.
module tb_tick_scheduler;

   localparam int P  = 4;
   localparam int PW = 16;

   logic          clk;
   logic          rst;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_ch;
   logic [PW-1:0] cfg_period;
   logic          cfg_en;
   logic          cfg_done;
   logic [3:0]    tick;
   logic [3:0]    tog;
   logic [3:0]    ch_en;

   int n_vec = 0;
   int n_err = 0;

   tick_scheduler #(.PRESCALE(P), .PW(PW)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_period (cfg_period),
      .cfg_en     (cfg_en),
      .cfg_done   (cfg_done),
      .tick       (tick),
      .tog        (tog),
      .ch_en      (ch_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   int        m_t;        // cycles since reset release (current cycle number)
   bit        m_known;
   int        m_per [4];
   bit        m_en  [4];
   int        m_n   [4];  // base ticks seen since commit while enabled
   logic [3:0] m_tick;
   logic [3:0] m_tog;
   bit        m_pend;     // request accepted and not yet past cfg_done
   int        m_tc;       // commit cycle of the pending request
   int        m_rch, m_rper;
   bit        m_ren;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, m_t, got, exp);
      end
   endtask

   function automatic int next_commit(input int t_acc);
      // first base tick strictly after the accept cycle
      if (t_acc % P == P - 1) return t_acc + P;
      return (t_acc / P) * P + P - 1;
   endfunction

   always begin
      @(negedge clk);
      #2;
      if (m_known) begin
         logic [3:0] exp_en;
         for (int i = 0; i < 4; i++) exp_en[i] = m_en[i];
         check("model_ready", 32'(cfg_ready), 32'(!m_pend && !rst));
         check("model_done",  32'(cfg_done),  32'(m_pend && (m_t == m_tc + 1)));
         check("model_tick",  32'(tick),      32'(m_tick));
         check("model_tog",   32'(tog),       32'(m_tog));
         check("model_chen",  32'(ch_en),     32'(exp_en));
      end
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_per[i] = 0; m_en[i] = 0; m_n[i] = 0;
         end
         m_tick = '0; m_tog = '0; m_pend = 0; m_tc = 0;
         m_t = 0; m_known = 1;
      end else if (m_known) begin
         bit         bt;
         bit         commit;
         logic [3:0] nt;
         bt     = (m_t % P) == P - 1;
         commit = m_pend && (m_t == m_tc);
         nt     = '0;
         for (int i = 0; i < 4; i++) begin
            if (commit && i == m_rch) begin
               m_per[i] = m_rper;
               m_en[i]  = m_ren && (m_rper != 0);
               m_n[i]   = 0;
               m_tog[i] = 1'b0;
            end else if (bt && m_en[i]) begin
               m_n[i]++;
               if (m_n[i] % m_per[i] == 0) nt[i] = 1'b1;
               m_tog[i] = ((m_n[i] / m_per[i]) % 2) == 1;
            end
         end
         m_tick = nt;
         if (m_pend && m_t == m_tc + 1) begin
            m_pend = 0;
         end else if (!m_pend && cfg_valid) begin
            m_pend = 1;
            m_rch  = int'(cfg_ch);
            m_rper = int'(cfg_period);
            m_ren  = cfg_en;
            m_tc   = next_commit(m_t);
         end
         m_t++;
      end
   end

   // ---------------- directed table ----------------
   typedef struct {
      int         cyc;
      logic       valid;
      logic [1:0] ch;
      logic [15:0] per;
      logic       en;
      logic [3:0] tick;
      logic [3:0] tog;
      logic [3:0] chen;
      logic       done;
      logic       ready;
   } vec_t;

   vec_t vecs [11];

   task automatic do_cfg(input logic [1:0] ch, input logic [15:0] per, input logic en,
                         output int t_done);
      int n;
      int t_acc;
      @(negedge clk);
      rst = 1'b0; cfg_valid = 1'b1; cfg_ch = ch; cfg_period = per; cfg_en = en;
      n = 0;
      #1;
      while (!cfg_ready && n < 2 * P) begin
         @(negedge clk); #1; n++;
      end
      t_acc = m_t;
      @(negedge clk);
      cfg_valid = 1'b0;
      n = 0;
      #1;
      while (!cfg_done && n < P + 2) begin
         @(negedge clk); #1; n++;
      end
      check("cfg_done_seen", 32'(cfg_done), 32'(1));
      t_done = m_t;
      check("cfg_latency", 32'(t_done), 32'(next_commit(t_acc) + 1));
   endtask

   initial begin
      int t_d0, t_d1, t_d2, n;
      bit acc_last;

      vecs[0]  = '{1,  1'b1, 2'd0, 16'd3, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};
      vecs[1]  = '{2,  1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[2]  = '{3,  1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0};
      vecs[3]  = '{4,  1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h1, 1'b1, 1'b0};
      vecs[4]  = '{5,  1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b1};
      vecs[5]  = '{15, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b1};
      vecs[6]  = '{16, 1'b0, 2'd0, 16'd0, 1'b0, 4'h1, 4'h1, 4'h1, 1'b0, 1'b1};
      vecs[7]  = '{17, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h1, 4'h1, 1'b0, 1'b1};
      vecs[8]  = '{28, 1'b0, 2'd0, 16'd0, 1'b0, 4'h1, 4'h0, 4'h1, 1'b0, 1'b1};
      vecs[9]  = '{29, 1'b0, 2'd0, 16'd0, 1'b0, 4'h0, 4'h0, 4'h1, 1'b0, 1'b1};
      vecs[10] = '{40, 1'b0, 2'd0, 16'd0, 1'b0, 4'h1, 4'h1, 4'h1, 1'b0, 1'b1};

      m_known = 0; m_t = 0;
      rst = 1'b1; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; cfg_en = 1'b0;

      // reset held three cycles
      repeat (2) begin
         @(negedge clk); #1;
         check("rst_outputs", 32'({tick, tog, ch_en, cfg_done}), 32'(0));
         check("rst_ready",   32'(cfg_ready), 32'(0));
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("cyc0_ready",   32'(cfg_ready), 32'(1));
      check("cyc0_outputs", 32'({tick, tog, ch_en, cfg_done}), 32'(0));

      // single channel: ch0 period 3 accepted at cycle 1
      for (int v = 0; v < 11; v++) begin
         n = 0;
         forever begin
            @(negedge clk);
            if (m_t >= vecs[v].cyc || n > 100) break;
            cfg_valid = 1'b0;
            n++;
         end
         cfg_valid = vecs[v].valid; cfg_ch = vecs[v].ch;
         cfg_period = vecs[v].per;  cfg_en = vecs[v].en;
         #1;
         check("vec_tick",  32'(tick),      32'(vecs[v].tick));
         check("vec_tog",   32'(tog),       32'(vecs[v].tog));
         check("vec_chen",  32'(ch_en),     32'(vecs[v].chen));
         check("vec_done",  32'(cfg_done),  32'(vecs[v].done));
         check("vec_ready", 32'(cfg_ready), 32'(vecs[v].ready));
      end
      @(negedge clk);
      cfg_valid = 1'b0;

      // period 0 disables; period 1 ticks after every base tick
      do_cfg(2'd1, 16'd0, 1'b1, t_d0);
      check("p0_chen1", 32'(ch_en[1]), 32'(0));
      repeat (8) begin
         @(negedge clk); #1;
         check("p0_no_tick", 32'(tick[1]), 32'(0));
      end
      do_cfg(2'd1, 16'd1, 1'b1, t_d0);
      check("p1_chen1", 32'(ch_en[1]), 32'(1));
      repeat (8) begin
         @(negedge clk); #1;
         check("p1_tick", 32'(tick[1]), 32'(((m_t - 1) % P) == P - 1));
      end

      // commit landing on ch2's terminal base tick
      do_cfg(2'd2, 16'd2, 1'b1, t_d0);
      n = 0;
      while (m_t < t_d0 + 13 && n < 100) begin
         @(negedge clk); n++;
      end
      do_cfg(2'd2, 16'd5, 1'b1, t_d1);
      check("tc_done_cycle", 32'(t_d1), 32'(t_d0 + 16));
      check("tc_no_tick",    32'(tick[2]), 32'(0));
      n = 0;
      forever begin
         @(negedge clk); #1; n++;
         if (tick[2] || n > 40) break;
      end
      check("tc_next_tick", 32'(m_t), 32'(t_d1 + 20));

      // backpressure: second request held during WAIT/DONE
      @(negedge clk);
      cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd2; cfg_en = 1'b1;
      #1;
      check("bp_first_ready", 32'(cfg_ready), 32'(1));
      @(negedge clk);
      cfg_period = 16'd3;
      n = 0;
      forever begin
         #1;
         check("bp_ready_low", 32'(cfg_ready), 32'(0));
         if (cfg_done || n > P + 2) break;
         n++;
         @(negedge clk);
      end
      t_d2 = m_t;
      @(negedge clk); #1;
      check("bp_accept_after_done", 32'(cfg_ready), 32'(1));
      check("bp_accept_cycle",      32'(m_t),       32'(t_d2 + 1));
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (2 * P + 2) @(negedge clk);

      // reset while the FSM is in WAIT
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (m_t % P != P - 1 && n < 20);
      @(negedge clk);
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd7; cfg_en = 1'b1;
      #1;
      check("rmid_accept", 32'(cfg_ready), 32'(1));
      @(negedge clk);
      cfg_valid = 1'b0; rst = 1'b1;
      #1;
      check("rmid_ready_in_rst", 32'(cfg_ready), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rmid_ready", 32'(cfg_ready), 32'(1));
      check("rmid_outs",  32'({tick, ch_en, cfg_done}), 32'(0));
      repeat (2 * P) begin
         @(negedge clk); #1;
         check("rmid_no_done", 32'(cfg_done), 32'(0));
      end

      // randomized traffic against the model
      acc_last = 1'b1;
      repeat (600) begin
         @(negedge clk);
         if (!cfg_valid || acc_last) begin
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = 2'($urandom_range(0, 3));
            cfg_period = 16'($urandom_range(0, 5));
            cfg_en     = ($urandom_range(0, 3) != 0);
         end
         rst = ($urandom_range(0, 149) == 0);
         #1;
         acc_last = cfg_valid && cfg_ready;
      end
      @(negedge clk);
      cfg_valid = 1'b0; rst = 1'b0;
      repeat (3 * P) @(negedge clk);
      #3;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

endmodule
